// File: rtl/mic_capture_if.sv
// Pmod MIC3 pin bundle plus the sample/peak stream presented to downstream consumers.
// master = mic_capture, slave = ADC pins and the consumer side.
interface mic_capture_if;
  logic        J_MIC_MISO;
  logic        J_MIC_SS;
  logic        J_MIC_SCK;
  logic [11:0] sample;
  logic        sample_valid;
  logic [11:0] peak;
  logic        peak_valid;

  modport master (
    input  J_MIC_MISO,
    output J_MIC_SS, J_MIC_SCK, sample, sample_valid, peak, peak_valid
  );

  modport slave (
    output J_MIC_MISO,
    input  J_MIC_SS, J_MIC_SCK, sample, sample_valid, peak, peak_valid
  );
endinterface

// File: rtl/mic_capture.sv
// SPI capture of ADCS7476 frames at SAMPLE_HZ; sample_valid 1+33*SCLK_DIV cycles after tick; no backpressure.
// Optional windowed peak tracker enabled by defining MIC_PEAK_EN.
module mic_capture #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_HZ   = 20_000,
  parameter int SCLK_DIV    = 50,
  parameter int PEAK_WINDOW = 2000
) (
  input  logic          CLK,
  input  logic          RESETN,
  mic_capture_if.master mic
);
  localparam int P  = CLK_HZ / SAMPLE_HZ;
  localparam int TW = (P > 1) ? $clog2(P) : 1;
  localparam int HW = (2 * SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;

  generate
    if (P <= 33 * SCLK_DIV + 2) begin : g_bad_rate
      $error("mic_capture: sample period too short for one SPI frame");
    end
    if (PEAK_WINDOW < 1) begin : g_bad_window
      $error("mic_capture: PEAK_WINDOW must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick_cnt;
  logic [HW-1:0] r_half_cnt, w_half_nxt;
  logic [3:0]    r_bit_cnt, w_bit_nxt;
  logic [11:0]   r_shift;
  logic          r_ss, r_sck, w_ss_nxt, w_sck_nxt;
  logic [11:0]   r_sample;
  logic          r_sample_valid;
  logic          w_tick, w_cap, w_done;

  assign w_tick = (r_tick_cnt == TW'(P - 1));

  always_ff @(posedge CLK) begin
    if (!RESETN || w_tick) r_tick_cnt <= '0;
    else                   r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_half_nxt  = r_half_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_ss_nxt    = r_ss;
    w_sck_nxt   = r_sck;
    w_cap       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ss_nxt   = 1'b1;
        w_sck_nxt  = 1'b1;
        w_half_nxt = '0;
        w_bit_nxt  = '0;
        if (w_tick) begin
          w_state_nxt = SETUP;
          w_ss_nxt    = 1'b0;
        end
      end
      SETUP: begin
        if (r_half_cnt == HW'(SCLK_DIV - 1)) begin
          w_state_nxt = SHIFT;
          w_half_nxt  = '0;
          w_sck_nxt   = 1'b0;
        end else begin
          w_half_nxt = r_half_cnt + HW'(1);
        end
      end
      SHIFT: begin
        // Half counter covers one bit: low phase then high phase.
        if (r_half_cnt == HW'(SCLK_DIV - 1)) begin
          w_sck_nxt  = 1'b1;
          w_cap      = 1'b1;
          w_half_nxt = r_half_cnt + HW'(1);
        end else if (r_half_cnt == HW'(2 * SCLK_DIV - 1)) begin
          if (r_bit_cnt == 4'd15) begin
            w_state_nxt = DONE;
            w_ss_nxt    = 1'b1;
            w_done      = 1'b1;
          end else begin
            w_bit_nxt  = r_bit_cnt + 4'd1;
            w_half_nxt = '0;
            w_sck_nxt  = 1'b0;
          end
        end else begin
          w_half_nxt = r_half_cnt + HW'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state        <= IDLE;
      r_half_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_ss           <= 1'b1;
      r_sck          <= 1'b1;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_half_cnt     <= w_half_nxt;
      r_bit_cnt      <= w_bit_nxt;
      r_ss           <= w_ss_nxt;
      r_sck          <= w_sck_nxt;
      r_sample_valid <= w_done;
      // Only 12 bits are kept: the leading nibble shifts out the top.
      if (w_cap)  r_shift  <= {r_shift[10:0], mic.J_MIC_MISO};
      if (w_done) r_sample <= r_shift;
    end
  end

  assign mic.J_MIC_SS     = r_ss;
  assign mic.J_MIC_SCK    = r_sck;
  assign mic.sample       = r_sample;
  assign mic.sample_valid = r_sample_valid;

`ifdef MIC_PEAK_EN
  localparam int WW = (PEAK_WINDOW > 1) ? $clog2(PEAK_WINDOW) : 1;

  logic [WW-1:0] r_win_cnt;
  logic [11:0]   r_run_max, r_peak, w_max;
  logic          r_peak_valid;

  assign w_max = (r_sample > r_run_max) ? r_sample : r_run_max;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_win_cnt    <= '0;
      r_run_max    <= '0;
      r_peak       <= '0;
      r_peak_valid <= 1'b0;
    end else begin
      r_peak_valid <= 1'b0;
      if (r_sample_valid) begin
        if (r_win_cnt == WW'(PEAK_WINDOW - 1)) begin
          r_peak       <= w_max;
          r_peak_valid <= 1'b1;
          r_run_max    <= '0;
          r_win_cnt    <= '0;
        end else begin
          r_run_max <= w_max;
          r_win_cnt <= r_win_cnt + WW'(1);
        end
      end
    end
  end

  assign mic.peak       = r_peak;
  assign mic.peak_valid = r_peak_valid;
`else
  assign mic.peak       = 12'd0;
  assign mic.peak_valid = 1'b0;
`endif
endmodule
